// File: rtl/izh_spike_encoder.sv
// izh_spike_encoder: threshold-crossing spike detector with timestamped event FIFO.
// Optional refractory hold-off is compiled in with `define IZH_SPIKE_REFRACT_EN.
module izh_spike_encoder #(
  parameter int DATA_W     = 16,
  parameter int V_THRESH   = 30,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int REFRACT    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] v,
  input  logic                     v_valid,
  output logic                     spike,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic                     overflow,
  output logic [15:0]              spike_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [DATA_W-1:0] THR = DATA_W'(V_THRESH);
  logic [TS_W-1:0] ts_q, mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;
  logic [15:0]     spk_cnt_q;
  logic            above_q, spike_q, ovf_q;
  logic            hit, det, full, pop, push;
  assign hit = v >= THR;
`ifdef IZH_SPIKE_REFRACT_EN
  localparam int RW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);
  logic [RW-1:0] refr_q;
  assign det = v_valid & hit & ~above_q & (refr_q == '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) refr_q <= '0;
    else if (det) refr_q <= RW'(REFRACT);
    else if (v_valid && refr_q != '0) refr_q <= refr_q - 1'b1;
`else
  logic refract_unused;
  assign refract_unused = REFRACT != 0;
  assign det = v_valid & hit & ~above_q;
`endif
  assign full        = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign ev_valid    = cnt_q != '0;
  assign pop         = ev_valid & ev_ready;
  assign push        = det & (~full | pop);
  assign ev_ts       = mem_q[rd_q];
  assign spike       = spike_q;
  assign overflow    = ovf_q;
  assign spike_count = spk_cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q      <= '0;
      above_q   <= 1'b0;
      spike_q   <= 1'b0;
      ovf_q     <= 1'b0;
      spk_cnt_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (v_valid) begin
        ts_q    <= ts_q + 1'b1;
        above_q <= hit;
      end
      spike_q <= det;
      if (det && spk_cnt_q != 16'hFFFF) spk_cnt_q <= spk_cnt_q + 1'b1;
      if (det && full && !pop) ovf_q <= 1'b1;
      if (push) begin
        mem_q[wr_q] <= ts_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule
